// File: rtl/carry_ahead_subtractor16_pipe.sv
// Two-stage 16-bit borrow-lookahead subtractor (diff = a - b - bin) with valid/ready
// handshakes, exporting group borrow generate/propagate and signed overflow.
module carry_ahead_subtractor16_pipe #(
    parameter int WIDTH = 16,
    parameter int GRP   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             Gm,
    output logic             Pm,
    output logic             ovf
);

    localparam int NGRP = WIDTH / GRP;

    // Per-group borrow generate/propagate, packed as {G[NGRP-1:0], P[NGRP-1:0]}.
    function automatic logic [2*NGRP-1:0] grp_terms(input logic [WIDTH-1:0] x,
                                                     input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [NGRP-1:0]  gg;
        logic [NGRP-1:0]  pp;
        logic             acc;
        g = ~x & y;
        p = ~(x ^ y);
        for (int k = 0; k < NGRP; k++) begin
            acc = 1'b0;
            for (int i = 0; i < GRP; i++)
                acc = g[k*GRP+i] | (p[k*GRP+i] & acc);
            gg[k] = acc;
            pp[k] = &p[k*GRP +: GRP];
        end
        return {gg, pp};
    endfunction

    function automatic logic group_gen(input logic [NGRP-1:0] G,
                                       input logic [NGRP-1:0] P);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < NGRP; k++)
            acc = G[k] | (P[k] & acc);
        return acc;
    endfunction

    // Group borrows come from G/P first; each group then resolves its own bit borrows.
    function automatic logic [WIDTH:0] bit_borrows(input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y,
                                                   input logic             bi,
                                                   input logic [NGRP-1:0]  G,
                                                   input logic [NGRP-1:0]  P);
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [NGRP:0]    gc;
        logic [WIDTH:0]   br;
        g = ~x & y;
        p = ~(x ^ y);
        gc[0] = bi;
        for (int k = 0; k < NGRP; k++)
            gc[k+1] = G[k] | (P[k] & gc[k]);
        br = '0;
        for (int k = 0; k < NGRP; k++) begin
            br[k*GRP] = gc[k];
            for (int i = 0; i < GRP-1; i++)
                br[k*GRP+i+1] = g[k*GRP+i] | (p[k*GRP+i] & br[k*GRP+i]);
        end
        br[WIDTH] = gc[NGRP];
        return br;
    endfunction

    logic             r_vld_p1;
    logic             r_vld_p2;
    logic [WIDTH-1:0] r_a_p1;
    logic [WIDTH-1:0] r_b_p1;
    logic             r_bin_p1;
    logic [NGRP-1:0]  r_G_p1;
    logic [NGRP-1:0]  r_P_p1;
    logic [WIDTH-1:0] r_diff_p2;
    logic             r_bout_p2;
    logic             r_Gm_p2;
    logic             r_Pm_p2;
    logic             r_ovf_p2;

    logic             w_acc;
    logic             w_load2;
    logic [2*NGRP-1:0] w_gp;
    logic [WIDTH:0]   w_br;

    assign in_ready = ~r_vld_p1 | ~r_vld_p2 | out_ready;
    assign w_acc    = in_valid & in_ready;
    assign w_load2  = r_vld_p1 & (~r_vld_p2 | out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else begin
            if (w_acc)
                r_vld_p1 <= 1'b1;
            else if (w_load2)
                r_vld_p1 <= 1'b0;
            if (w_load2)
                r_vld_p2 <= 1'b1;
            else if (out_ready)
                r_vld_p2 <= 1'b0;
        end
    end

    // ---- stage 1: operands and group G/P ----
    assign w_gp = grp_terms(a, b);

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_a_p1   <= a;
            r_b_p1   <= b;
            r_bin_p1 <= bin;
            r_G_p1   <= w_gp[2*NGRP-1:NGRP];
            r_P_p1   <= w_gp[NGRP-1:0];
        end
    end

    // ---- stage 2: borrow resolution and result ----
    assign w_br = bit_borrows(r_a_p1, r_b_p1, r_bin_p1, r_G_p1, r_P_p1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff_p2 <= '0;
            r_bout_p2 <= 1'b0;
            r_Gm_p2   <= 1'b0;
            r_Pm_p2   <= 1'b0;
            r_ovf_p2  <= 1'b0;
        end else if (w_load2) begin
            r_diff_p2 <= r_a_p1 ^ r_b_p1 ^ w_br[WIDTH-1:0];
            r_bout_p2 <= w_br[WIDTH];
            r_Gm_p2   <= group_gen(r_G_p1, r_P_p1);
            r_Pm_p2   <= &r_P_p1;
            r_ovf_p2  <= w_br[WIDTH-1] ^ w_br[WIDTH];
        end
    end

    assign out_valid = r_vld_p2;
    assign diff      = r_diff_p2;
    assign bout      = r_bout_p2;
    assign Gm        = r_Gm_p2;
    assign Pm        = r_Pm_p2;
    assign ovf       = r_ovf_p2;

endmodule

// File: tb/tb_carry_ahead_subtractor16_pipe.sv
// Bench for carry_ahead_subtractor16_pipe: directed corner cases, backpressure, reset
// mid-flight and randomized traffic against an arithmetic reference model.
module tb_carry_ahead_subtractor16_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        Gm;
    logic        Pm;
    logic        ovf;

    carry_ahead_subtractor16_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .Gm        (Gm),
        .Pm        (Pm),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] diff;
        logic        bout;
        logic        gm;
        logic        pm;
        logic        ovf;
        int          acc;
    } res_t;

    res_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic bi);
        res_t        m;
        logic [16:0] full;
        int          sd;
        full  = {1'b0, x} - {1'b0, y} - 17'(bi);
        sd    = int'($signed(x)) - int'($signed(y)) - int'(bi);
        m.diff = full[15:0];
        m.bout = full[16];
        m.gm   = (x < y);
        m.pm   = (x == y);
        m.ovf  = (sd > 32767) || (sd < -32768);
        m.acc  = 0;
        return m;
    endfunction

    // One clock cycle: drive at the falling edge, check handshake and outputs, record accept.
    task automatic step(input logic v, input logic [15:0] aa, input logic [15:0] bb,
                        input logic bi, input logic ordy, output logic accepted);
        res_t e;
        logic exp_ov;
        @(negedge clk);
        in_valid  = v;
        a         = aa;
        b         = bb;
        bin       = bi;
        out_ready = ordy;
        #1;
        chk("in_ready", in_ready, (q.size() < 2) || ordy);
        exp_ov = (q.size() > 0) && (cyc >= q[0].acc + 2);
        chk("out_valid", out_valid, exp_ov);
        if (out_valid && q.size() > 0) begin
            chk("diff", diff, q[0].diff);
            chk("flags", {bout, Gm, Pm, ovf}, {q[0].bout, q[0].gm, q[0].pm, q[0].ovf});
            if (ordy)
                void'(q.pop_front());
        end
        accepted = v && in_ready;
        if (accepted) begin
            e     = model(aa, bb, bi);
            e.acc = cyc;
            q.push_back(e);
        end
        cyc++;
    endtask

    task automatic directed(input string tag, input logic [15:0] aa, input logic [15:0] bb,
                            input logic bi, input logic [15:0] ed, input logic eb,
                            input logic egm, input logic epm, input logic eov);
        logic acc;
        step(1'b1, aa, bb, bi, 1'b1, acc);
        chk({tag, "_acc"}, acc, 1);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
        chk({tag, "_lat"}, out_valid, 0);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
        chk({tag, "_vld"}, out_valid, 1);
        chk({tag, "_diff"}, diff, ed);
        chk({tag, "_bout"}, bout, eb);
        chk({tag, "_gm"}, Gm, egm);
        chk({tag, "_pm"}, Pm, epm);
        chk({tag, "_ovf"}, ovf, eov);
    endtask

    function automatic logic [15:0] pick();
        logic [15:0] edges [4];
        edges[0] = 16'h0000;
        edges[1] = 16'hFFFF;
        edges[2] = 16'h7FFF;
        edges[3] = 16'h8000;
        if ($urandom_range(3) == 0)
            return edges[$urandom_range(3)];
        return 16'($urandom);
    endfunction

    initial begin
        logic        acc;
        logic [15:0] ops_a [4];
        logic [15:0] ops_b [4];
        logic [15:0] ra;
        logic [15:0] rb;
        int          idx;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'h0;
        b         = 16'h0;
        bin       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outs", {diff, bout, Gm, Pm, ovf}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        directed("borrow", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0);
        directed("eq_b1",  16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        directed("eq_b0",  16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        directed("ovf_neg", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1);
        directed("ovf_pos", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);
        directed("bmax_a0", 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        directed("bmax_a1", 16'h1234, 16'hFFFF, 1'b1, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0);
        directed("bmax_af", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);

        // Backpressure: four back-to-back inputs, consumer stalled for the first cycles.
        ops_a[0] = 16'h0010; ops_b[0] = 16'h0003;
        ops_a[1] = 16'h0003; ops_b[1] = 16'h0010;
        ops_a[2] = 16'hABCD; ops_b[2] = 16'h1111;
        ops_a[3] = 16'h8000; ops_b[3] = 16'h7FFF;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            if (idx < 4)
                step(1'b1, ops_a[idx], ops_b[idx], 1'b0, c >= 5, acc);
            else
                step(1'b0, 16'h0, 16'h0, 1'b0, c >= 5, acc);
            if (c == 2) begin
                chk("bp_in_ready", in_ready, 0);
                chk("bp_hold", diff, 16'h000D);
            end
            if (acc)
                idx++;
        end
        chk("bp_all_accepted", idx, 4);
        chk("bp_drained", q.size(), 0);

        // Reset with two operations in flight.
        step(1'b1, 16'h5555, 16'h1111, 1'b0, 1'b0, acc);
        step(1'b1, 16'h2222, 16'h3333, 1'b1, 1'b0, acc);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        chk("pre_rst_vld", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_vld", out_valid, 0);
        chk("midrst_outs", {diff, bout, Gm, Pm, ovf}, 0);
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        for (int c = 0; c < 5; c++)
            step(1'b0, 16'h0, 16'h0, 1'b0, c[0], acc);

        // Randomized traffic.
        for (int n = 0; n < 10000; n++) begin
            ra = pick();
            rb = ($urandom_range(15) == 0) ? ra : pick();
            step($urandom_range(3) != 0, ra, rb, 1'($urandom), $urandom_range(3) != 0, acc);
        end
        for (int c = 0; c < 20 && q.size() > 0; c++)
            step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
        chk("final_drain", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
